// File: rtl/minmaxavg_stream.sv
// Streaming min/max/average over frames of 2**LOG2_N samples, results held until consumed.
// Define MINMAXAVG_SIGNED_EN for two's-complement samples; the default build is unsigned.
module minmaxavg_stream #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_avg,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SumW = WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] LastCnt = {LOG2_N{1'b1}};

`ifdef MINMAXAVG_SIGNED_EN
    localparam logic [WIDTH-1:0] MinInit = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MaxInit = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

    function automatic logic [SumW-1:0] ext(input logic [WIDTH-1:0] a);
        return {{LOG2_N{a[WIDTH-1]}}, a};
    endfunction
`else
    localparam logic [WIDTH-1:0] MinInit = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MaxInit = {WIDTH{1'b0}};

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return a < b;
    endfunction

    function automatic logic [SumW-1:0] ext(input logic [WIDTH-1:0] a);
        return {{LOG2_N{1'b0}}, a};
    endfunction
`endif

    typedef enum logic [0:0] {StAccum, StHold} state_e;

    state_e            state_q, state_d;
    logic [LOG2_N-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  min_q, min_d, max_q, max_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic [WIDTH-1:0]  out_min_q, out_min_d, out_max_q, out_max_d, out_avg_q, out_avg_d;
    logic              out_valid_q, out_valid_d;

    logic              accept, first;
    logic [WIDTH-1:0]  new_min, new_max;
    logic [SumW-1:0]   new_sum;

    always_comb begin
        in_ready = (state_q == StAccum) && !RESET;
        accept   = in_valid && in_ready && !clear;
        first    = (cnt_q == '0);
        new_min  = (first || less(in_data, min_q)) ? in_data : min_q;
        new_max  = (first || less(max_q, in_data)) ? in_data : max_q;
        new_sum  = first ? ext(in_data) : sum_q + ext(in_data);

        state_d     = state_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        sum_d       = sum_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        out_avg_d   = out_avg_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            // Zero count makes the next accept reload the running values.
            state_d     = StAccum;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        min_d = new_min;
                        max_d = new_max;
                        sum_d = new_sum;
                        if (cnt_q == LastCnt) begin
                            out_min_d   = new_min;
                            out_max_d   = new_max;
                            // Shift by LOG2_N then truncate to WIDTH == upper WIDTH bits of sum.
                            out_avg_d   = new_sum[SumW-1:LOG2_N];
                            out_valid_d = 1'b1;
                            state_d     = StHold;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + LOG2_N'(1);
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        state_d     = StAccum;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = StAccum;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StAccum;
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            out_min_q   <= MinInit;
            out_max_q   <= MaxInit;
            out_avg_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            sum_q       <= sum_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            out_avg_q   <= out_avg_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_min   = out_min_q;
    assign out_max   = out_max_q;
    assign out_avg   = out_avg_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_minmaxavg_stream.sv
// Directed bench: a 4-sample-frame instance (most scenarios) and an 8-sample-frame instance.
module tb_minmaxavg_stream;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       clear, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid;
    logic [7:0] out_min, out_max, out_avg;

    logic       clear3, in_valid3, out_ready3;
    logic [7:0] in_data3;
    logic       in_ready3, out_valid3;
    logic [7:0] out_min3, out_max3, out_avg3;

    int nvec = 0;
    int nerr = 0;

`ifdef MINMAXAVG_SIGNED_EN
    localparam logic [7:0] MinInit = 8'h7F;
    localparam logic [7:0] MaxInit = 8'h80;
    // 5,-3,100,-128 -> sum -26, floor(-26/4) = -7
    localparam logic [7:0] AMin = 8'h80, AMax = 8'h64, AAvg = 8'hF9;
    // -56,10,-1,3 -> sum -44 -> -11
    localparam logic [7:0] BMin = 8'hC8, BMax = 8'h0A, BAvg = 8'hF5;
`else
    localparam logic [7:0] MinInit = 8'hFF;
    localparam logic [7:0] MaxInit = 8'h00;
    // 5,253,100,128 -> sum 486 -> 121
    localparam logic [7:0] AMin = 8'h05, AMax = 8'hFD, AAvg = 8'h79;
    // 200,10,255,3 -> sum 468 -> 117
    localparam logic [7:0] BMin = 8'h03, BMax = 8'hFF, BAvg = 8'h75;
`endif

    minmaxavg_stream #(.WIDTH(8), .LOG2_N(2)) dut (
        .CLK(CLK), .RESET(RESET), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_min(out_min), .out_max(out_max), .out_avg(out_avg),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    minmaxavg_stream #(.WIDTH(8), .LOG2_N(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .clear(clear3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_min(out_min3), .out_max(out_max3), .out_avg(out_avg3),
        .out_valid(out_valid3), .out_ready(out_ready3)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic release_results();
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h11;
        cyc();
        cyc();
        nvec++;
        if (in_ready !== 1'b0) begin
            nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b0, MinInit, MaxInit, 8'h00}) begin
            nerr++;
            $display("FAIL reset_outputs got v=%b %h/%h/%h want v=0 %h/%h/00",
                     out_valid, out_min, out_max, out_avg, MinInit, MaxInit);
        end
        in_valid = 1'b0;
        RESET = 1'b0;
        cyc();
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL post_reset got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_frame_a();
        send(8'h05); send(8'hFD); send(8'h64);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL frame_a_early got v=%b want 0", out_valid);
        end
        send(8'h80);
        nvec++;
        if ({out_valid, in_ready, out_min, out_max, out_avg} !== {2'b10, AMin, AMax, AAvg}) begin
            nerr++;
            $display("FAIL frame_a got v=%b rdy=%b %h/%h/%h want v=1 rdy=0 %h/%h/%h",
                     out_valid, in_ready, out_min, out_max, out_avg, AMin, AMax, AAvg);
        end
        release_results();
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_min !== AMin) begin
            nerr++;
            $display("FAIL frame_a_release got v=%b rdy=%b min=%h want 0/1/%h",
                     out_valid, in_ready, out_min, AMin);
        end
    endtask

    task automatic test_back_to_back();
        send(8'hC8); send(8'h0A); send(8'hFF); send(8'h03);
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b1, BMin, BMax, BAvg}) begin
            nerr++;
            $display("FAIL frame_b got v=%b %h/%h/%h want v=1 %h/%h/%h",
                     out_valid, out_min, out_max, out_avg, BMin, BMax, BAvg);
        end
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cyc();
            nvec++;
            if ({in_ready, out_valid, out_min, out_max, out_avg} !== {2'b01, BMin, BMax, BAvg})
            begin
                nerr++;
                $display("FAIL hold_stable[%0d] got rdy=%b v=%b %h/%h/%h", i,
                         in_ready, out_valid, out_min, out_max, out_avg);
            end
        end
        in_data = 8'h77;
        release_results();
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL hold_release got v=%b rdy=%b want 0/1", out_valid, in_ready);
        end
        send(8'h01); send(8'h02); send(8'h03);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL release_sample_counted got v=%b want 0", out_valid);
        end
        send(8'h04);
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b1, 8'h01, 8'h04, 8'h02}) begin
            nerr++;
            $display("FAIL fresh_frame got v=%b %h/%h/%h want v=1 01/04/02",
                     out_valid, out_min, out_max, out_avg);
        end
        release_results();
    endtask

    task automatic test_clear();
        send(8'h5A); send(8'h5A);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h32;
        cyc();
        clear    = 1'b0;
        in_valid = 1'b0;
        send(8'h01); send(8'h02); send(8'h03);
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++; $display("FAIL clear_sample_counted got v=%b want 0", out_valid);
        end
        send(8'h04);
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b1, 8'h01, 8'h04, 8'h02}) begin
            nerr++;
            $display("FAIL clear_frame got v=%b %h/%h/%h want v=1 01/04/02",
                     out_valid, out_min, out_max, out_avg);
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_max !== 8'h04) begin
            nerr++;
            $display("FAIL clear_in_hold got v=%b rdy=%b max=%h want 0/1/04",
                     out_valid, in_ready, out_max);
        end
    endtask

    task automatic test_reset_mid();
        send(8'h10); send(8'h20); send(8'h30);
        RESET = 1'b1;
        cyc();
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b0, MinInit, MaxInit, 8'h00}) begin
            nerr++;
            $display("FAIL reset_mid got v=%b %h/%h/%h", out_valid, out_min, out_max, out_avg);
        end
        RESET = 1'b0;
        send(8'h08); send(8'h08); send(8'h08); send(8'h0C);
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b1, 8'h08, 8'h0C, 8'h09}) begin
            nerr++;
            $display("FAIL after_reset_frame got v=%b %h/%h/%h want v=1 08/0c/09",
                     out_valid, out_min, out_max, out_avg);
        end
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        nvec++;
        if ({out_valid, out_min, out_max, out_avg} !== {1'b0, MinInit, MaxInit, 8'h00}) begin
            nerr++;
            $display("FAIL reset_hold got v=%b %h/%h/%h", out_valid, out_min, out_max, out_avg);
        end
    endtask

    task automatic test_equal();
        in_data3 = 8'h07;
        for (int i = 0; i < 8; i++) begin
            in_valid3 = 1'b1;
            cyc();
            in_valid3 = 1'b0;
            if (i == 6) begin
                nvec++;
                if (out_valid3 !== 1'b0) begin
                    nerr++; $display("FAIL equal_early got v=%b want 0", out_valid3);
                end
            end
        end
        nvec++;
        if ({out_valid3, out_min3, out_max3, out_avg3} !== {1'b1, 8'h07, 8'h07, 8'h07}) begin
            nerr++;
            $display("FAIL equal_frame got v=%b %h/%h/%h want v=1 07/07/07",
                     out_valid3, out_min3, out_max3, out_avg3);
        end
    endtask

    initial begin
        RESET = 1'b1;
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        clear3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_data3 = 8'h00;
        test_reset();
        test_frame_a();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_equal();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/minmaxavg_stream.md
MINMAXAVG_STREAM -- requirements
Module: minmaxavg_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the sample and result width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter LOG2_N, default 3, meaning log2 of the frame length N in samples (legal range 1..8).
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port clear  input  1  synchronous frame abort.
REQ-006 The block SHALL have port in_data  input  WIDTH  sample value.
REQ-007 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-008 The block SHALL have port in_ready  output  1  the block can accept a sample.
REQ-009 The block SHALL have port out_min  output  WIDTH  frame minimum.
REQ-010 The block SHALL have port out_max  output  WIDTH  frame maximum.
REQ-011 The block SHALL have port out_avg  output  WIDTH  frame average.
REQ-012 The block SHALL have port out_valid  output  1  results are valid.
REQ-013 The block SHALL have port out_ready  input  1  the consumer accepts the results.

Function
REQ-014 The block SHALL have two states: ACCUM and HOLD.
REQ-015 in_ready SHALL be 1 in ACCUM and 0 in HOLD.
REQ-016 A sample SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 Running min, max and sum SHALL each be updated on every accept.
- The first accept of a frame loads in_data directly into all three.
- Later accepts compare and add.
REQ-018 The sum accumulator SHALL be WIDTH+LOG2_N bits wide, so it never overflows.
REQ-019 On the N-th accept, the block SHALL register the results and enter HOLD, with out_valid=1 on the next cycle (latency 1 cycle from the last accept).
- out_min and out_max take the final running values.
- out_avg = final sum shifted right by LOG2_N, truncated to WIDTH bits.
REQ-020 In HOLD, out_min, out_max, out_avg and out_valid SHALL remain stable until out_ready=1.
REQ-021 In HOLD with out_ready=1, the block SHALL go to ACCUM with out_valid=0 and the sample count at 0 on the next cycle.
- Result outputs keep their values until the next frame completes.
REQ-022 In HOLD, in_valid SHALL be ignored; no sample is lost or counted.
REQ-023 A sample presented in the same cycle as out_ready in HOLD SHALL NOT be accepted.
REQ-024 clear=1 SHALL, from any state, on the next cycle:
- enter ACCUM;
- set the sample count to 0;
- set out_valid=0;
- discard running min, max and sum.
REQ-025 clear SHALL take priority over a simultaneous accept and over out_ready; result outputs keep their last values.
REQ-026 A sample equal to the running min or max SHALL leave that value unchanged.

Reset
REQ-027 While RESET=1, the block SHALL force the following on each rising CLK edge:
- state ACCUM, sample count 0, out_valid=0, out_avg=0;
- out_min=MIN_INIT and out_max=MAX_INIT.
REQ-028 While RESET=1, in_ready SHALL be 0, and any in_valid SHALL be ignored.
REQ-029 RESET SHALL take priority over clear and all other inputs.
REQ-030 A reset asserted mid-frame or in HOLD SHALL discard the frame.
REQ-031 MIN_INIT and MAX_INIT SHALL take these values:
- Signed mode: MIN_INIT = 2^(WIDTH-1)-1 and MAX_INIT = -2^(WIDTH-1) (127 and -128 for WIDTH=8).
- Unsigned mode: MIN_INIT = 2^WIDTH-1 and MAX_INIT = 0.

Configuration
REQ-032 With macro MINMAXAVG_SIGNED_EN defined, the block SHALL treat samples as two's complement.
- Compares are signed.
- The sum is sign-extended.
- The average shift is arithmetic, i.e. floor division.
REQ-033 Without MINMAXAVG_SIGNED_EN, the block SHALL treat samples as unsigned.
- Compares are unsigned.
- The sum is zero-extended.
- The average shift is logical.

Verification
REQ-034 The bench SHALL cover the signed-frame case: MINMAXAVG_SIGNED_EN, WIDTH=8, LOG2_N=2, samples 5,-3,100,-128 -> out_min=-128, out_max=100, out_avg=-7, out_valid=1 one cycle after the 4th accept.
REQ-035 The bench SHALL cover the unsigned-frame case: no macro, WIDTH=8, LOG2_N=2, samples 200,10,255,3 -> out_min=3, out_max=255, out_avg=117.
REQ-036 The bench SHALL cover backpressure: frame complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle; the next 4 samples form a fresh frame.
REQ-037 The bench SHALL cover clear mid-frame: 2 samples 90,90, then clear=1 with in_valid=1, then samples 1,2,3,4 -> out_min=1, out_max=4, out_avg=2; the sample presented with clear is not counted.
REQ-038 The bench SHALL cover reset mid-frame: RESET=1 after 3 accepts or in HOLD -> next cycle out_valid=0, out_min=127, out_max=-128 (signed) or 255/0 (unsigned), out_avg=0.
REQ-039 The bench SHALL cover equal samples: WIDTH=8, LOG2_N=3, eight samples of 7 -> out_min=out_max=out_avg=7.
